// File: rtl/intr_ctrl_pkg.sv
// Constants shared by the interrupt controller and the trap unit: register offsets,
// machine interrupt cause codes, mip bit positions and the request FSM encoding.
package intr_ctrl_pkg;

  localparam logic [4:0] OFF_MSIP        = 5'h00;
  localparam logic [4:0] OFF_MTIMECMP_LO = 5'h04;
  localparam logic [4:0] OFF_MTIMECMP_HI = 5'h08;
  localparam logic [4:0] OFF_MTIME_LO    = 5'h0C;
  localparam logic [4:0] OFF_MTIME_HI    = 5'h10;
  localparam logic [4:0] OFF_EXT_PENDING = 5'h14;
  localparam logic [4:0] OFF_EXT_ENABLE  = 5'h18;
  localparam logic [4:0] OFF_CLAIM       = 5'h1C;

  localparam logic [4:0] CAUSE_MSI = 5'd3;
  localparam logic [4:0] CAUSE_MTI = 5'd7;
  localparam logic [4:0] CAUSE_MEI = 5'd11;

  localparam int MIP_MSIP_BIT = 3;
  localparam int MIP_MTIP_BIT = 7;
  localparam int MIP_MEIP_BIT = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } irq_state_e;

  // Fixed machine-level priority: external > software > timer.
  function automatic logic [4:0] pick_cause(input logic msi, input logic mti, input logic mei);
    if (mei)      return CAUSE_MEI;
    else if (msi) return CAUSE_MSI;
    else if (mti) return CAUSE_MTI;
    else          return 5'd0;
  endfunction

endpackage

// File: rtl/intr_gateway.sv
// Edge-triggered external interrupt gateway: per-source pending / in-service state
// and the lowest-index claim encoder.
module intr_gateway
  import intr_ctrl_pkg::*;
#(
  parameter int NSRC = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NSRC-1:0] src_irq,
  input  logic [NSRC-1:0] enable,
  input  logic            claim_rd,
  input  logic            complete_wr,
  input  logic [31:0]     complete_id,
  output logic [NSRC-1:0] pending,
  output logic [NSRC-1:0] in_service,
  output logic [4:0]      claim_id,
  output logic            claimable
);

  logic [NSRC-1:0] src_q;
  logic [NSRC-1:0] edge_det;
  logic [NSRC-1:0] cand;
  logic [NSRC-1:0] claim_mask;
  logic [NSRC-1:0] take_mask;
  logic [NSRC-1:0] complete_mask;

  assign edge_det  = src_irq & ~src_q;
  // Sources already in service are invisible to claim and to MEIP.
  assign cand      = pending & enable & ~in_service;
  assign claimable = |cand;
  assign take_mask = claim_rd ? claim_mask : '0;

  always_comb begin
    claim_id   = '0;
    claim_mask = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (cand[i]) begin
        claim_id      = 5'(i + 1);
        claim_mask    = '0;
        claim_mask[i] = 1'b1;
      end
    end
  end

  // Ids of 0 or above NSRC match no source; completing an idle source is a no-op.
  always_comb begin
    complete_mask = '0;
    for (int i = 0; i < NSRC; i++) begin
      complete_mask[i] = complete_wr && (complete_id == 32'(i + 1));
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      src_q      <= '0;
      pending    <= '0;
      in_service <= '0;
    end else begin
      src_q      <= src_irq;
      pending    <= (pending & ~take_mask) | edge_det;
      in_service <= (in_service & ~complete_mask) | take_mask;
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Machine interrupt controller: CLINT-style timer, software interrupt bit,
// external gateway registers and the held interrupt request to the trap unit.
module intr_ctrl
  import intr_ctrl_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NSRC     = 8,
  parameter int TICK_DIV = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            bus_sel,
  input  logic            bus_we,
  input  logic [4:0]      bus_addr,
  input  logic [31:0]     bus_wdata,
  output logic [31:0]     bus_rdata,
  input  logic [NSRC-1:0] src_irq,
  input  logic            mstatus_mie,
  input  logic [XLEN-1:0] mie,
  output logic [XLEN-1:0] mip,
  output logic            irq_req,
  output logic [XLEN-1:0] irq_cause,
  input  logic            irq_ack,
  output irq_state_e      dbg_state
);

  logic [63:0]     mtime;
  logic [63:0]     mtimecmp;
  logic [31:0]     presc;
  logic            tick;
  logic            msip;
  logic            mtip_q;
  logic            meip_q;
  logic [NSRC-1:0] ext_enable;
  logic [NSRC-1:0] ext_pending;
  logic [NSRC-1:0] ext_in_service;
  logic [4:0]      claim_id;
  logic            claimable;
  logic [4:0]      word_off;
  logic            wr_en;
  logic            rd_en;
  logic [31:0]     rdata_mux;
  logic            addr_lsb_unused;
  logic [XLEN-1:0] act_bits;
  logic            any_active;
  logic            still_active;
  logic [XLEN-1:0] new_cause;
  irq_state_e      state;

  assign word_off        = {bus_addr[4:2], 2'b00};
  assign addr_lsb_unused = ^bus_addr[1:0];
  assign wr_en           = bus_sel & bus_we;
  assign rd_en           = bus_sel & ~bus_we;
  assign tick            = (presc == 32'(TICK_DIV - 1));
  assign dbg_state       = state;

  intr_gateway #(.NSRC(NSRC)) u_gateway (
    .clock       (clock),
    .reset       (reset),
    .src_irq     (src_irq),
    .enable      (ext_enable),
    .claim_rd    (rd_en && (word_off == OFF_CLAIM)),
    .complete_wr (wr_en && (word_off == OFF_CLAIM)),
    .complete_id (bus_wdata),
    .pending     (ext_pending),
    .in_service  (ext_in_service),
    .claim_id    (claim_id),
    .claimable   (claimable)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc      <= '0;
      mtime      <= '0;
      mtimecmp   <= '1;
      msip       <= 1'b0;
      ext_enable <= '0;
      mtip_q     <= 1'b0;
      meip_q     <= 1'b0;
    end else begin
      presc  <= tick ? '0 : presc + 32'd1;
      mtip_q <= (mtime >= mtimecmp);
      meip_q <= claimable;
      // A bus write to mtime swallows a coincident increment.
      if (wr_en && word_off == OFF_MTIME_LO)      mtime[31:0]  <= bus_wdata;
      else if (wr_en && word_off == OFF_MTIME_HI) mtime[63:32] <= bus_wdata;
      else if (tick)                              mtime        <= mtime + 64'd1;
      if (wr_en) begin
        case (word_off)
          OFF_MSIP:        msip            <= bus_wdata[0];
          OFF_MTIMECMP_LO: mtimecmp[31:0]  <= bus_wdata;
          OFF_MTIMECMP_HI: mtimecmp[63:32] <= bus_wdata;
          OFF_EXT_ENABLE:  ext_enable      <= bus_wdata[NSRC-1:0];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rdata_mux = '0;
    case (word_off)
      OFF_MSIP:        rdata_mux[0]        = msip;
      OFF_MTIMECMP_LO: rdata_mux           = mtimecmp[31:0];
      OFF_MTIMECMP_HI: rdata_mux           = mtimecmp[63:32];
      OFF_MTIME_LO:    rdata_mux           = mtime[31:0];
      OFF_MTIME_HI:    rdata_mux           = mtime[63:32];
      OFF_EXT_PENDING: rdata_mux[NSRC-1:0] = ext_pending;
      OFF_EXT_ENABLE:  rdata_mux[NSRC-1:0] = ext_enable;
      OFF_CLAIM:       rdata_mux[4:0]      = claim_id;
      default: ;
    endcase
  end

  assign bus_rdata = bus_sel ? rdata_mux : '0;

  always_comb begin
    mip               = '0;
    mip[MIP_MSIP_BIT] = msip;
    mip[MIP_MTIP_BIT] = mtip_q;
    mip[MIP_MEIP_BIT] = meip_q;
  end

  // Cause codes equal their mip bit positions, so the held cause indexes act_bits.
  assign act_bits     = mip & mie & {XLEN{mstatus_mie}};
  assign any_active   = |act_bits;
  assign still_active = act_bits[irq_cause[4:0]];

  always_comb begin
    new_cause         = '0;
    new_cause[XLEN-1] = 1'b1;
    new_cause[4:0]    = pick_cause(act_bits[MIP_MSIP_BIT], act_bits[MIP_MTIP_BIT],
                                   act_bits[MIP_MEIP_BIT]);
  end

  // Handshake: irq_req rises with irq_cause stable and holds until a one-cycle
  // irq_ack (or the interrupt deactivates); acks outside REQ are ignored.
  // WAIT re-evaluates like IDLE, so irq_req is low for exactly one cycle after an ack.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      irq_req   <= 1'b0;
      irq_cause <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_WAIT: begin
          if (any_active) begin
            state     <= ST_REQ;
            irq_req   <= 1'b1;
            irq_cause <= new_cause;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_REQ: begin
          if (irq_ack) begin
            state   <= ST_WAIT;
            irq_req <= 1'b0;
          end else if (!still_active) begin
            state   <= ST_IDLE;
            irq_req <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          irq_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: timer compare, prescaler wrap, gateway claim/complete,
// cause priority across acks and reset during a held request.
module tb_intr_ctrl;
  import intr_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        bus_sel = 1'b0, bus_we = 1'b0;
  logic [4:0]  bus_addr = '0;
  logic [31:0] bus_wdata = '0, bus_rdata;
  logic [7:0]  src_irq = '0;
  logic        mstatus_mie = 1'b0;
  logic [31:0] mie = '0, mip, irq_cause;
  logic        irq_req, irq_ack = 1'b0;
  irq_state_e  dbg_state;

  logic        b4_sel = 1'b0, b4_we = 1'b0;
  logic [4:0]  b4_addr = '0;
  logic [31:0] b4_wdata = '0, b4_rdata, mip4, cause4;
  logic        req4;
  irq_state_e  dbg_state4;

  logic [63:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;

  intr_ctrl #(.XLEN(32), .NSRC(8), .TICK_DIV(1)) dut (
    .clock(clock), .reset(reset), .bus_sel(bus_sel), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .src_irq(src_irq), .mstatus_mie(mstatus_mie), .mie(mie), .mip(mip),
    .irq_req(irq_req), .irq_cause(irq_cause), .irq_ack(irq_ack), .dbg_state(dbg_state)
  );

  intr_ctrl #(.XLEN(32), .NSRC(8), .TICK_DIV(4)) dut4 (
    .clock(clock), .reset(reset), .bus_sel(b4_sel), .bus_we(b4_we),
    .bus_addr(b4_addr), .bus_wdata(b4_wdata), .bus_rdata(b4_rdata),
    .src_irq(8'h00), .mstatus_mie(1'b0), .mie(32'h0), .mip(mip4),
    .irq_req(req4), .irq_cause(cause4), .irq_ack(1'b0), .dbg_state(dbg_state4)
  );

  // Clock and watchdog
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wr(input bit u4, input logic [4:0] a, input logic [31:0] d);
    if (u4) begin b4_sel = 1'b1; b4_we = 1'b1; b4_addr = a; b4_wdata = d; end
    else    begin bus_sel = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d; end
    tick();
    bus_sel = 1'b0; bus_we = 1'b0; b4_sel = 1'b0; b4_we = 1'b0;
  endtask

  task automatic rd(input bit u4, input logic [4:0] a, output logic [31:0] d);
    if (u4) begin b4_sel = 1'b1; b4_we = 1'b0; b4_addr = a; end
    else    begin bus_sel = 1'b1; bus_we = 1'b0; bus_addr = a; end
    #1;
    d = u4 ? b4_rdata : bus_rdata;
    tick();
    bus_sel = 1'b0; b4_sel = 1'b0;
  endtask

  task automatic pulse_src(input logic [7:0] v);
    src_irq = v;
    tick();
    src_irq = '0;
  endtask

  task automatic ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic expect_val(input logic [63:0] v);
    exp_q.push_back(v);
  endtask

  // Scoreboard: pops the oldest expectation and compares it with the observation
  task automatic chk(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s: observed=%0h required=<no expectation queued>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s: observed=%0h required=%0h", tag, obs, e);
      end
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] v0;
    bit          found;

    tick(3);
    expect_val(0); chk("reset_irq_req", irq_req);
    expect_val(0); chk("reset_irq_cause", irq_cause);
    expect_val(0); chk("reset_mip", mip);
    reset = 1'b1;
    tick();
    expect_val(32'hFFFF_FFFF); rd(0, OFF_MTIMECMP_LO, d); chk("reset_mtimecmp_lo", d);
    expect_val(32'hFFFF_FFFF); rd(0, OFF_MTIMECMP_HI, d); chk("reset_mtimecmp_hi", d);
    expect_val(0);             rd(0, OFF_MSIP, d);        chk("reset_msip", d);
    expect_val(0);             rd(0, OFF_EXT_ENABLE, d);  chk("reset_ext_enable", d);
    ack();
    expect_val(0);       chk("ack_in_idle_req", irq_req);
    expect_val(ST_IDLE); chk("ack_in_idle_state", dbg_state);

    // Timer compare, TICK_DIV=1
    wr(0, OFF_MTIMECMP_HI, 32'h0);
    wr(0, OFF_MTIMECMP_LO, 32'd20);
    wr(0, OFF_MTIME_HI, 32'h0);
    wr(0, OFF_MTIME_LO, 32'h0);
    tick(19);
    expect_val(19); rd(0, OFF_MTIME_LO, d); chk("mtime_count", d);
    expect_val(0);  chk("mtip_before_match", mip[7]);
    tick();
    expect_val(1);  chk("mtip_after_match", mip[7]);
    mie = 32'h80; mstatus_mie = 1'b1;
    tick();
    expect_val(1);            chk("mti_req", irq_req);
    expect_val(32'h8000_0007); chk("mti_cause", irq_cause);
    expect_val(ST_REQ);       chk("mti_state", dbg_state);
    tick(3);
    expect_val(1);            chk("mti_req_held", irq_req);
    expect_val(32'h8000_0007); chk("mti_cause_held", irq_cause);
    ack();
    expect_val(0); chk("mti_req_low_after_ack", irq_req);
    tick();
    expect_val(1); chk("mti_req_reraised", irq_req);
    mstatus_mie = 1'b0;
    tick();
    expect_val(0);       chk("deactivate_req", irq_req);
    expect_val(ST_IDLE); chk("deactivate_state", dbg_state);
    mie = '0;
    wr(0, OFF_MTIMECMP_HI, 32'hFFFF_FFFF);
    wr(0, OFF_MTIMECMP_LO, 32'hFFFF_FFFF);

    // Prescaler and 64-bit wrap, TICK_DIV=4: align to an increment first
    b4_sel = 1'b1; b4_we = 1'b0; b4_addr = OFF_MTIME_LO;
    #1;
    v0 = b4_rdata;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (b4_rdata != v0) found = 1'b1;
    end
    b4_sel = 1'b0;
    expect_val(1); chk("prescaler_align", found);
    wr(1, OFF_MTIME_HI, 32'hFFFF_FFFF);
    wr(1, OFF_MTIME_LO, 32'hFFFF_FFFF);
    tick();
    expect_val(32'hFFFF_FFFF); rd(1, OFF_MTIME_LO, d); chk("wrap_before_lo", d);
    expect_val(0);             rd(1, OFF_MTIME_LO, d); chk("wrap_after_lo", d);
    expect_val(0);             rd(1, OFF_MTIME_HI, d); chk("wrap_after_hi", d);
    tick();
    wr(1, OFF_MTIME_LO, 32'h1234_5678);
    expect_val(32'h1234_5678); rd(1, OFF_MTIME_LO, d); chk("write_wins_increment", d);
    tick(2);
    expect_val(32'h1234_5678); rd(1, OFF_MTIME_LO, d); chk("prescale_hold", d);
    expect_val(32'h1234_5679); rd(1, OFF_MTIME_LO, d); chk("prescale_step", d);

    // External claim/complete
    wr(0, OFF_EXT_ENABLE, 32'hFFFF_FF0A);
    expect_val(32'h0A); rd(0, OFF_EXT_ENABLE, d); chk("enable_width", d);
    pulse_src(8'h0A);
    tick();
    expect_val(32'h0A); rd(0, OFF_EXT_PENDING, d); chk("ext_pending_both", d);
    expect_val(1);      chk("meip_set", mip[11]);
    expect_val(2);      rd(0, OFF_CLAIM, d); chk("claim_first", d);
    expect_val(4);      rd(0, OFF_CLAIM, d); chk("claim_second", d);
    expect_val(0);      rd(0, OFF_CLAIM, d); chk("claim_empty", d);
    expect_val(0);      chk("meip_dropped", mip[11]);
    expect_val(0);      rd(0, OFF_EXT_PENDING, d); chk("ext_pending_cleared", d);
    wr(0, OFF_CLAIM, 32'd9);
    wr(0, OFF_CLAIM, 32'd0);

    // Edge while in service
    pulse_src(8'h02);
    tick(2);
    expect_val(32'h02); rd(0, OFF_EXT_PENDING, d); chk("pending_in_service", d);
    expect_val(0);      chk("meip_masked_in_service", mip[11]);
    expect_val(0);      rd(0, OFF_CLAIM, d); chk("claim_excludes_service", d);
    wr(0, OFF_CLAIM, 32'd2);
    tick();
    expect_val(1);      chk("meip_after_complete", mip[11]);
    expect_val(2);      rd(0, OFF_CLAIM, d); chk("claim_after_complete", d);
    wr(0, OFF_CLAIM, 32'd4);
    wr(0, OFF_CLAIM, 32'd2);

    // Edge in the same cycle as the claim keeps pending
    pulse_src(8'h02);
    tick();
    src_irq = 8'h02;
    expect_val(2);      rd(0, OFF_CLAIM, d); chk("claim_with_edge", d);
    src_irq = '0;
    expect_val(32'h02); rd(0, OFF_EXT_PENDING, d); chk("pending_kept_by_edge", d);
    wr(0, OFF_CLAIM, 32'd2);
    expect_val(2);      rd(0, OFF_CLAIM, d); chk("claim_repeat", d);
    wr(0, OFF_CLAIM, 32'd2);

    // Priority across acks: MEI > MSI > MTI
    mie = 32'h888;
    wr(0, OFF_MSIP, 32'h1);
    wr(0, OFF_MTIMECMP_HI, 32'h0);
    wr(0, OFF_MTIMECMP_LO, 32'h0);
    pulse_src(8'h08);
    tick(2);
    expect_val(32'h888); chk("mip_all", mip);
    mstatus_mie = 1'b1;
    tick();
    expect_val(1);             chk("mei_req", irq_req);
    expect_val(32'h8000_000B); chk("mei_cause", irq_cause);
    ack();
    expect_val(0);             chk("mei_low_after_ack", irq_req);
    tick();
    expect_val(1);             chk("mei_reraised", irq_req);
    expect_val(32'h8000_000B); chk("mei_cause_again", irq_cause);
    expect_val(4); rd(0, OFF_CLAIM, d); chk("claim_src3", d);
    tick(2);
    expect_val(0);             chk("mei_withdrawn", irq_req);
    tick();
    expect_val(1);             chk("msi_req", irq_req);
    expect_val(32'h8000_0003); chk("msi_cause", irq_cause);
    ack();
    expect_val(0);             chk("msi_low_after_ack", irq_req);
    tick();
    expect_val(1);             chk("msi_reraised", irq_req);
    wr(0, OFF_MSIP, 32'h0);
    tick();
    expect_val(0);             chk("msi_withdrawn", irq_req);
    tick();
    expect_val(1);             chk("mti_req2", irq_req);
    expect_val(32'h8000_0007); chk("mti_cause2", irq_cause);
    ack();
    expect_val(0);             chk("mti_low_after_ack", irq_req);
    tick();
    expect_val(1);             chk("mti_before_reset", irq_req);

    // Reset during a held request
    reset = 1'b0;
    #1;
    expect_val(0);       chk("reset_mid_req", irq_req);
    expect_val(0);       chk("reset_mid_mip", mip);
    expect_val(0);       chk("reset_mid_cause", irq_cause);
    expect_val(ST_IDLE); chk("reset_mid_state", dbg_state);
    tick(2);
    reset = 1'b1;
    tick();
    expect_val(32'hFFFF_FFFF); rd(0, OFF_MTIMECMP_LO, d); chk("post_reset_cmp_lo", d);
    expect_val(32'hFFFF_FFFF); rd(0, OFF_MTIMECMP_HI, d); chk("post_reset_cmp_hi", d);
    expect_val(0);             rd(0, OFF_EXT_PENDING, d); chk("post_reset_pending", d);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/intr_ctrl.md
Name: intr_ctrl

Overview:
Machine-level interrupt source for the core: a CLINT-style timer (mtime/mtimecmp), a software interrupt bit and a small edge-triggered external-interrupt gateway with claim/complete.
Drives the MTIP/MSIP/MEIP pending bits the trap unit mirrors into mip.
Raises a held interrupt request with a stable mcause value; the trap unit consumes it and acknowledges on trap entry.
Sits on the core's memory-mapped peripheral bus next to the trap/CSR logic.

Parameters:
XLEN, 32, data and cause width (32 only on the bus; cause uses XLEN).
NSRC, 8, number of external interrupt sources (1..31).
TICK_DIV, 1, clock cycles per mtime increment (>=1).

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low
bus_sel  in  1  register access strobe, single cycle
bus_we  in  1  1 = write, 0 = read
bus_addr  in  5  byte offset; bits [1:0] ignored
bus_wdata  in  32  write data
bus_rdata  out  32  read data, combinational on bus_addr; 0 when bus_sel=0
src_irq  in  NSRC  external interrupt lines, synchronous to clock
mstatus_mie  in  1  global machine interrupt enable
mie  in  XLEN  mie CSR contents
mip  out  XLEN  bit3 = MSIP, bit7 = MTIP, bit11 = MEIP, others 0
irq_req  out  1  interrupt request to the trap unit
irq_cause  out  XLEN  mcause value; valid while irq_req=1
irq_ack  in  1  one-cycle pulse: trap unit has taken the interrupt

Behaviour:
- Reset values:
  - mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0.
  - ext pending=0, enable=0, in-service=0, prescaler=0, src edge history=0.
  - irq_req=0, irq_cause=0, mip=0.
  - Reset mid-operation aborts any held request immediately.
- Register map (32-bit, word offsets):
  - 0x00 MSIP: bit0 R/W.
  - 0x04 MTIMECMP_LO, 0x08 MTIMECMP_HI: R/W.
  - 0x0C MTIME_LO, 0x10 MTIME_HI: R/W.
  - 0x14 EXT_PENDING: RO; bit i = source i.
  - 0x18 EXT_ENABLE: R/W; bits >= NSRC read 0.
  - 0x1C CLAIM: read/write, see claim/complete below.
  - Unmapped offsets read 0; writes to them are ignored.
- Timer:
  - Prescaler counts 0..TICK_DIV-1; mtime increments by 1 when it wraps.
  - 64-bit wrap from all-ones to 0.
  - A bus write to MTIME_LO/HI in the same cycle as an increment: the write wins and that increment is lost.
  - mip[7] is registered mtime >= mtimecmp (unsigned), so it updates one cycle after either value changes.
- mip[3] = msip bit.
- Gateway, per source:
  - A rising edge on src_irq[i] (registered history) sets pending[i].
  - An edge while in_service[i]=1 still sets pending[i]; one-deep, further edges are lost.
- mip[11] = |(pending & enable), registered.
- Claim/complete:
  - Read of CLAIM returns id = lowest index i with pending & enable set, plus 1; returns 0 if none.
  - For id != 0 the read clears pending[i] and sets in_service[i].
  - A new edge on the same source in the same cycle as the claim leaves pending[i]=1.
  - While in_service[i]=1, source i is excluded from claim selection and from MEIP.
  - Write of id to CLAIM clears in_service[id-1].
  - Writes of 0, of an id > NSRC, or of an id not in service are ignored.
- Request FSM, states IDLE, REQ, WAIT:
  - IDLE: active = mstatus_mie & (mip & mie) != 0. If active, latch irq_cause = {1'b1, code} with code priority 11 > 3 > 7; go to REQ.
  - REQ: irq_req=1 and irq_cause held stable. On irq_ack go to WAIT. If the interrupt deactivates before ack (bit cleared or mstatus_mie=0), drop irq_req and go to IDLE; this is not an error.
  - WAIT: irq_req=0 for exactly one cycle, then IDLE re-evaluates. irq_ack outside REQ is ignored.

Decomposition:
- Shared package or header: register offsets, interrupt cause codes (MSI=3, MTI=7, MEI=11) and mip bit positions. The trap unit uses the same constants.
- One sub-module, intr_gateway (NSRC wide): edge detect, pending/in-service and claim priority encoder.
- Timer, register file and request FSM stay in intr_ctrl.

Test Plan:
- Timer compare: TICK_DIV=1; write MTIMECMP_HI=0, MTIMECMP_LO=20, MTIME=0. Expect mip[7]=0 until mtime reaches 20, then mip[7]=1 one cycle later. With mie[7]=1 and mstatus_mie=1, irq_cause=0x80000007 and irq_req held until irq_ack.
- Prescaler/wrap: TICK_DIV=4; write MTIME=64'hFFFF_FFFF_FFFF_FFFF. After 4 cycles MTIME_LO=0 and MTIME_HI=0. A write on the increment cycle leaves exactly the written value.
- External claim: EXT_ENABLE=0x0A; pulse src 1 and 3 together. CLAIM reads 2, then 4, then 0. MEIP drops after the second claim. Write 2 to CLAIM clears in_service[1]; write 9 changes nothing.
- Edge during service: claim src 1, pulse src 1 again. EXT_PENDING=0x02 but MEIP=0 until complete id 2 is written; then MEIP=1.
- Priority/handshake: MSIP=1, mtime>=mtimecmp and MEIP all active together, all enabled. Cause sequence across acks is 0x8000000B; then with MEIP claimed, 0x80000003; then with MSIP cleared, 0x80000007. irq_req is low exactly one cycle after each ack.
- Reset mid-request: assert reset while in REQ. irq_req=0 at once, mip=0, mtimecmp reads all ones after reset release.
